// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-side cache responder.
// The optional ICACHE_PERF_CNT_EN build adds hit/miss counters in the top.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        UPDATE
    } state_t;

    localparam int WORD_W   = 32;
    localparam int BLOCK_W  = 128;
    localparam int OFFSET_W = 4;

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int addr_w, input int lines);
        return addr_w - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and instruction-memory-side signals of the cache responder.
// The slave modport is the cache's view; master is the PC/memory environment.
interface icache_responder_if #(
    parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0]                 PC;
  logic                              read;
  logic [icache_pkg::WORD_W-1:0]     instruction;
  logic                              busyWait;
  logic [ADDR_W-icache_pkg::OFFSET_W-1:0] mem_address;
  logic                              mem_read;
  logic [icache_pkg::BLOCK_W-1:0]    mem_readdata;
  logic                              mem_busywait;

  modport slave (
    input  PC, read, mem_readdata, mem_busywait,
    output instruction, busyWait, mem_address, mem_read
  );

  modport master (
    output PC, read, mem_readdata, mem_busywait,
    input  instruction, busyWait, mem_address, mem_read
  );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the direct-mapped instruction cache.
// Lookup is combinational; a write installs a whole line on the clock edge.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IDX_W = 3,
  parameter int TAG_W = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic [LINES-1:0]   valid_reg;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [BLOCK_W-1:0] data_mem [LINES];

  // Only the valid bits are reset; stale tag/data are harmless behind them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Fetch-stage instruction cache responder: hit lookup, miss stall and block refill.
// Define ICACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module icache_responder
  import icache_pkg::*;
#(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  icache_responder_if.slave  bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  localparam int IDX_W   = index_width(LINES);
  localparam int TAG_W   = tag_width(ADDR_W, LINES);
  localparam int SEL_W   = $clog2(WORDS_PER_LINE);
  localparam int BADDR_W = ADDR_W - OFFSET_W;

  state_t             state_reg;
  logic [BADDR_W-1:0] blk_addr_reg;
  logic [BLOCK_W-1:0] fill_data_reg;
  logic               mem_read_reg;
  logic [BADDR_W-1:0] mem_address_reg;

  logic [IDX_W-1:0]   pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [SEL_W-1:0]   pc_sel;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic               hit;
  logic               miss_req;
  logic               unused_pc_bits;

  assign pc_index       = bus.PC[OFFSET_W +: IDX_W];
  assign pc_tag         = bus.PC[ADDR_W-1 -: TAG_W];
  assign pc_sel         = bus.PC[2 +: SEL_W];
  assign unused_pc_bits = ^bus.PC[1:0];

  icache_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_line_store (
    .clk      (CLK),
    .rst_n    (RESET),
    .rd_index (pc_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (state_reg == UPDATE),
    .wr_index (blk_addr_reg[IDX_W-1:0]),
    .wr_tag   (blk_addr_reg[BADDR_W-1 -: TAG_W]),
    .wr_data  (fill_data_reg)
  );

  assign hit      = line_valid && (line_tag == pc_tag);
  assign miss_req = bus.read && !hit;

  // Outputs are forced quiet while reset is held, even with read asserted.
  assign bus.busyWait    = RESET && ((state_reg != IDLE) || miss_req);
  assign bus.instruction = RESET ? line_data[WORD_W*pc_sel +: WORD_W] : '0;
  assign bus.mem_read    = mem_read_reg;
  assign bus.mem_address = mem_address_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg       <= IDLE;
      blk_addr_reg    <= '0;
      fill_data_reg   <= '0;
      mem_read_reg    <= 1'b0;
      mem_address_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss_req) begin
            state_reg       <= MEM_READ;
            blk_addr_reg    <= bus.PC[ADDR_W-1:OFFSET_W];
            mem_read_reg    <= 1'b1;
            mem_address_reg <= bus.PC[ADDR_W-1:OFFSET_W];
          end
        end
        MEM_READ: begin
          if (!bus.mem_busywait) begin
            state_reg       <= UPDATE;
            fill_data_reg   <= bus.mem_readdata;
            mem_read_reg    <= 1'b0;
            mem_address_reg <= '0;
          end
        end
        UPDATE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (bus.read && hit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_req && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_reg;
  assign miss_count = miss_cnt_reg;
`endif

endmodule
